// File: rtl/ram_stream_reader.sv
// Burst reader: issues sequential reads to a 1-cycle-latency synchronous RAM and
// streams the returned words through a 4-entry FIFO with valid/ready handshake.
module ram_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned OCC_W      = 3;
  localparam int unsigned CNT_W      = ADDR_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state, state_n;
  logic [ADDR_WIDTH-1:0] next_addr, next_addr_n;
  logic [ADDR_WIDTH-1:0] read_addr_n;
  logic [CNT_W-1:0]      issue_left, issue_left_n;
  logic [CNT_W-1:0]      xfer_left, xfer_left_n;
  logic                  rd_en_n;
  logic                  busy_n;
  logic                  done_n;

  // pend marks the ram_q cycle of a read issued in the previous cycle
  logic                  pend;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [OCC_W-1:0]      occ, occ_n;
  logic [DATA_WIDTH-1:0] head_c;
  logic [DATA_WIDTH-1:0] out_data_n;
  logic                  out_valid_n;
  logic                  push_c, pop_c, room_c;

  // FIFO bookkeeping and next head word presented on the stream
  always_comb begin
    pop_c       = out_valid & out_ready;
    push_c      = pend;
    occ_n       = occ + OCC_W'(push_c) - OCC_W'(pop_c);
    wr_ptr_n    = wr_ptr + PTR_W'(push_c);
    rd_ptr_n    = rd_ptr + PTR_W'(pop_c);
    head_c      = (push_c && (wr_ptr == rd_ptr_n)) ? ram_q : mem[rd_ptr_n];
    out_valid_n = (occ_n != '0);
    out_data_n  = out_valid_n ? head_c : out_data;
    // the read issued now is still in flight next cycle, so it counts against room
    room_c      = (occ_n + OCC_W'(rd_en)) < OCC_W'(FIFO_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, read issue and burst counters
  always_comb begin
    state_n      = state;
    rd_en_n      = 1'b0;
    read_addr_n  = read_addr;
    next_addr_n  = next_addr;
    issue_left_n = issue_left;
    xfer_left_n  = pop_c ? (xfer_left - CNT_W'(1)) : xfer_left;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_n      = S_RUN;
            rd_en_n      = 1'b1;
            read_addr_n  = base_addr;
            next_addr_n  = base_addr + ADDR_WIDTH'(1);
            issue_left_n = count - CNT_W'(1);
            xfer_left_n  = count;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (issue_left == '0) begin
          state_n = S_DRAIN;
        end else if (room_c) begin
          rd_en_n      = 1'b1;
          read_addr_n  = next_addr;
          next_addr_n  = next_addr + ADDR_WIDTH'(1);
          issue_left_n = issue_left - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (pop_c && (xfer_left == CNT_W'(1))) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr  <= '0;
      read_addr  <= '0;
      rd_en      <= 1'b0;
      issue_left <= '0;
      xfer_left  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      next_addr  <= next_addr_n;
      read_addr  <= read_addr_n;
      rd_en      <= rd_en_n;
      issue_left <= issue_left_n;
      xfer_left  <= xfer_left_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      pend      <= rd_en;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      occ       <= occ_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= ram_q;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized bench for ram_stream_reader: a queue-based burst model checked every
// cycle, plus literal expectations for latency, wrap-around, count=0 and reset.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  count;
  logic [3:0]  read_addr;
  logic        rd_en;
  logic [31:0] ram_q;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .read_addr(read_addr), .rd_en(rd_en), .ram_q(ram_q), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  function automatic logic [31:0] ram_word(input logic [3:0] a);
    return 32'hA0 + 32'(a);
  endfunction

  // Synchronous RAM; garbage on ram_q when no read was issued
  always @(posedge clk) ram_q <= rd_en ? ram_word(read_addr) : $urandom();

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          m_phase = 0;
  logic [31:0] exp_q[$];
  int          m_to_issue = 0;
  int          m_issued = 0;
  int          m_xfer = 0;
  logic [3:0]  m_next_addr = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  int          start_cyc = 0;
  int          done_cyc = -1;
  logic [31:0] xlog[$];
  int          xcyc[$];
  logic [3:0]  alog[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    cmp("busy", 32'(busy), 32'(m_phase != 0));
    cmp("done", 32'(done), 32'(m_phase == 2));
    if (exp_q.size() == 0) cmp("valid_when_empty", 32'(out_valid), 32'd0);
    if (prev_stall) begin
      cmp("stall_valid", 32'(out_valid), 32'd1);
      cmp("stall_data", out_data, prev_data);
    end
    if (rd_en) begin
      if (m_to_issue == 0) begin
        cmp("rd_en_extra", 32'(rd_en), 32'd0);
      end else begin
        cmp("read_addr", 32'(read_addr), 32'(m_next_addr));
        cmp("fifo_room", 32'(m_issued - m_xfer < 4), 32'd1);
        alog.push_back(read_addr);
        m_next_addr++;
        m_to_issue--;
        m_issued++;
      end
    end
    if (done) done_cyc = cyc;
  endtask

  task automatic model_edge(input logic st, input logic [3:0] ba, input logic [4:0] cnt,
                            input logic rdy);
    if (out_valid && rdy && exp_q.size() != 0) begin
      cmp("out_data", out_data, exp_q[0]);
      xlog.push_back(out_data);
      xcyc.push_back(cyc);
      void'(exp_q.pop_front());
      m_xfer++;
    end
    prev_stall = out_valid && !rdy;
    prev_data  = out_data;
    if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 1 && exp_q.size() == 0 && m_to_issue == 0) begin
      m_phase = 2;
    end else if (m_phase == 0 && st) begin
      start_cyc = cyc;
      if (cnt == 0) begin
        m_phase = 2;
      end else begin
        m_phase = 1;
        for (int i = 0; i < int'(cnt); i++) exp_q.push_back(ram_word(4'(ba + 4'(i))));
        m_to_issue  = int'(cnt);
        m_issued    = 0;
        m_xfer      = 0;
        m_next_addr = ba;
      end
    end
  endtask

  // One clock: check this cycle, drive inputs for the next edge, advance the model
  task automatic step(input logic st, input logic [3:0] ba, input logic [4:0] cnt,
                      input logic rdy);
    check_outputs();
    start     = st;
    base_addr = ba;
    count     = cnt;
    out_ready = rdy;
    model_edge(st, ba, cnt, rdy);
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      1:       return (k % 4 == 0) || (k % 4 == 3);
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  // mode 0: ready=1, 1: ready 1,0,0,1 pattern, 2: random, 3: ready=1 with a stray start
  task automatic run_burst(input int ba, input int cnt, input int mode);
    int n;
    logic st;
    xlog.delete();
    xcyc.delete();
    alog.delete();
    done_cyc = -1;
    step(1'b1, 4'(ba), 5'(cnt), ready_for(mode, 0));
    n = 0;
    while (m_phase != 0 && n < 300) begin
      st = (mode == 3 && n == 2);
      step(st, st ? 4'd9 : 4'($urandom()), st ? 5'd3 : 5'($urandom()), ready_for(mode, n + 1));
      n++;
    end
    cmp("burst_timeout", 32'(n < 300), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    cmp({tag, "_read_addr"}, 32'(read_addr), 32'd0);
    cmp({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    cmp({tag, "_out_data"}, out_data, 32'd0);
    cmp({tag, "_busy"}, 32'(busy), 32'd0);
    cmp({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    step(1'b0, 4'd0, 5'd0, 1'b1);

    // Base 2, count 4, ready held high
    run_burst(2, 4, 0);
    cmp("s1_words", 32'(xlog.size()), 32'd4);
    if (xlog.size() == 4) begin
      cmp("s1_first_latency", 32'(xcyc[0] - start_cyc), 32'd3);
      for (int i = 0; i < 4; i++) begin
        cmp("s1_data", xlog[i], 32'hA2 + 32'(i));
        cmp("s1_back_to_back", 32'(xcyc[i] - xcyc[0]), 32'(i));
      end
      cmp("s1_done_cycle", 32'(done_cyc - xcyc[3]), 32'd1);
    end

    // Address wrap
    run_burst(14, 4, 0);
    cmp("s2_reads", 32'(alog.size()), 32'd4);
    cmp("s2_words", 32'(xlog.size()), 32'd4);
    if (alog.size() == 4 && xlog.size() == 4) begin
      cmp("s2_addr0", 32'(alog[0]), 32'd14);
      cmp("s2_addr2", 32'(alog[2]), 32'd0);
      cmp("s2_data1", xlog[1], 32'hAF);
      cmp("s2_data3", xlog[3], 32'hA1);
    end

    // Full-depth burst with 1,0,0,1 backpressure
    run_burst(0, 16, 1);
    cmp("s3_words", 32'(xlog.size()), 32'd16);
    if (xlog.size() == 16)
      for (int i = 0; i < 16; i++) cmp("s3_data", xlog[i], 32'hA0 + 32'(i));

    // Empty burst
    run_burst(5, 0, 0);
    cmp("s4_done_cycle", 32'(done_cyc - start_cyc), 32'd1);
    cmp("s4_reads", 32'(alog.size()), 32'd0);
    cmp("s4_words", 32'(xlog.size()), 32'd0);

    // Stray start during the burst
    run_burst(3, 5, 3);
    cmp("s5_words", 32'(xlog.size()), 32'd5);
    if (xlog.size() == 5) cmp("s5_last", xlog[4], 32'hA7);

    // Random bursts with random backpressure and idle gaps
    for (int b = 0; b < 14; b++) begin
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)), 2);
      n = int'($urandom_range(0, 3));
      for (int k = 0; k < n; k++) step(1'b0, 4'($urandom()), 5'($urandom()), 1'($urandom()));
    end

    // Reset after two of eight words
    xlog.delete();
    step(1'b1, 4'd0, 5'd8, 1'b1);
    n = 0;
    while (m_xfer < 2 && n < 50) begin
      step(1'b0, 4'd0, 5'd0, 1'b1);
      n++;
    end
    cmp("s6_two_words", 32'(xlog.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    m_phase = 0;
    m_to_issue = 0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step(1'b0, 4'd0, 5'd0, 1'b1);
    run_burst(7, 3, 0);
    cmp("s6_recover_words", 32'(xlog.size()), 32'd3);
    if (xlog.size() == 3) cmp("s6_recover_first", xlog[0], 32'hA7);
    step(1'b0, 4'd0, 5'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
